// File: rtl/bridge_fsm_pkg.sv
// Shared definitions for the memory-mapped I/O bridge: DM access-width codes,
// FSM state encodings and default device slot base addresses.
package bridge_fsm_pkg;

  localparam logic [2:0] DM_WORD = 3'd0;
  localparam logic [2:0] DM_HALF = 3'd1;
  localparam logic [2:0] DM_BYTE = 3'd2;

  typedef enum logic [1:0] {
    BR_IDLE = 2'd0,
    BR_REQ  = 2'd1,
    BR_DONE = 2'd2
  } br_state_e;

  localparam logic [31:0] BASE0_DEFAULT = 32'h0000_7F00;
  localparam logic [31:0] BASE1_DEFAULT = 32'h0000_7F10;
  localparam logic [31:0] BASE2_DEFAULT = 32'h0000_7F20;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/bridge_fsm_if.sv
// Device-side bus of the bridge: one-hot request/ack per slot, shared write
// data/offset, per-slot read data and raw interrupt lines.
interface bridge_fsm_if;

  logic [2:0]  dev_req;
  logic        dev_we;
  logic [1:0]  dev_addr;
  logic [31:0] dev_wdata;
  logic [2:0]  dev_ack;
  logic [31:0] dev_rdata0;
  logic [31:0] dev_rdata1;
  logic [31:0] dev_rdata2;
  logic [5:0]  dev_irq;

  modport master (
    output dev_req, dev_we, dev_addr, dev_wdata,
    input  dev_ack, dev_rdata0, dev_rdata1, dev_rdata2, dev_irq
  );

  modport slave (
    input  dev_req, dev_we, dev_addr, dev_wdata,
    output dev_ack, dev_rdata0, dev_rdata1, dev_rdata2, dev_irq
  );

endinterface

// File: rtl/bridge_fsm_addr_decode.sv
// Combinational slot decode: 16-byte window match per slot and access legality
// (exactly one hit, word width, word aligned).
module bridge_fsm_addr_decode
  import bridge_fsm_pkg::*;
#(
  parameter logic [31:0] BASE0 = BASE0_DEFAULT,
  parameter logic [31:0] BASE1 = BASE1_DEFAULT,
  parameter logic [31:0] BASE2 = BASE2_DEFAULT
) (
  input  logic [31:0] cpu_addr,
  input  logic [2:0]  dm_mode,
  output logic [2:0]  hit,
  output logic        legal
);

  // The word offset inside a slot is not part of the decode.
  logic unused_offset_s;
  assign unused_offset_s = ^cpu_addr[3:2];

  // Window match and legality
  always_comb begin
    hit[0] = (cpu_addr[31:4] == BASE0[31:4]);
    hit[1] = (cpu_addr[31:4] == BASE1[31:4]);
    hit[2] = (cpu_addr[31:4] == BASE2[31:4]);
    legal  = is_onehot3(hit) && (dm_mode == DM_WORD) && (cpu_addr[1:0] == 2'b00);
  end

endmodule

// File: rtl/bridge_fsm.sv
// MMIO bridge behind the CPU M stage: launches one req/ack transaction per legal
// access, stalls the pipeline until ack or timeout, and synchronises device IRQs.
module bridge_fsm
  import bridge_fsm_pkg::*;
#(
  parameter logic [31:0] BASE0   = BASE0_DEFAULT,
  parameter logic [31:0] BASE1   = BASE1_DEFAULT,
  parameter logic [31:0] BASE2   = BASE2_DEFAULT,
  parameter int          TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [31:0]       cpu_addr,
  input  logic              dev_write_enable,
  input  logic [2:0]        dm_mode,
  input  logic [31:0]       cpu_write_data,
  input  logic              bridge_stop,
  output logic [31:0]       cpu_read_result,
  output logic              bridge_valid,
  output logic              bridge_busy,
  output logic [7:2]        hwirq,
  bridge_fsm_if.master      dev
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  br_state_e        state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       sel_r;
  logic [2:0]       req_r;
  logic             we_r;
  logic [1:0]       addr_r;
  logic [31:0]      wdata_r;
  logic [31:0]      rdata_r;
  logic [5:0]       irq_meta_r;
  logic [5:0]       hwirq_r;

  logic [2:0]       hit_s;
  logic             legal_s;
  logic             launch_s;
  logic             ack_s;
  logic             timeout_s;
  logic [31:0]      sel_rdata_s;

  bridge_fsm_addr_decode #(
    .BASE0 (BASE0),
    .BASE1 (BASE1),
    .BASE2 (BASE2)
  ) u_decode (
    .cpu_addr (cpu_addr),
    .dm_mode  (dm_mode),
    .hit      (hit_s),
    .legal    (legal_s)
  );

  // Launch qualification, selected-slot ack and read data
  always_comb begin
    launch_s  = cpu_req & legal_s & ~bridge_stop;
    ack_s     = |(dev.dev_ack & sel_r);
    timeout_s = (cnt_r == CNT_MAX);
    case (sel_r)
      3'b001:  sel_rdata_s = dev.dev_rdata0;
      3'b010:  sel_rdata_s = dev.dev_rdata1;
      3'b100:  sel_rdata_s = dev.dev_rdata2;
      default: sel_rdata_s = 32'd0;
    endcase
  end

  // Next state and stall; bridge_valid is independent of state
  always_comb begin
    state_s      = state_r;
    bridge_busy  = 1'b0;
    bridge_valid = ~cpu_req | legal_s;
    case (state_r)
      BR_IDLE: begin
        bridge_busy = launch_s;
        if (launch_s) state_s = BR_REQ;
        else          state_s = BR_IDLE;
      end
      BR_REQ: begin
        bridge_busy = 1'b1;
        if (ack_s || timeout_s) state_s = BR_DONE;
        else                    state_s = BR_REQ;
      end
      BR_DONE: state_s = BR_IDLE;
      default: state_s = BR_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= BR_IDLE;
    else     state_r <= state_s;
  end

  // Transaction latch, wait counter and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      sel_r   <= 3'b000;
      req_r   <= 3'b000;
      we_r    <= 1'b0;
      addr_r  <= 2'b00;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
    end else begin
      case (state_r)
        BR_IDLE: begin
          if (launch_s) begin
            sel_r   <= hit_s;
            req_r   <= hit_s;
            we_r    <= dev_write_enable;
            addr_r  <= cpu_addr[3:2];
            wdata_r <= cpu_write_data;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        BR_REQ: begin
          // Ack wins over timeout when both land in the same cycle.
          if (ack_s) begin
            rdata_r <= we_r ? 32'd0 : sel_rdata_s;
            req_r   <= 3'b000;
          end else if (timeout_s) begin
            rdata_r <= 32'd0;
            req_r   <= 3'b000;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          req_r <= 3'b000;
        end
      endcase
    end
  end

  // Two-flop interrupt synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_meta_r <= 6'd0;
      hwirq_r    <= 6'd0;
    end else begin
      irq_meta_r <= dev.dev_irq;
      hwirq_r    <= irq_meta_r;
    end
  end

  assign dev.dev_req    = req_r;
  assign dev.dev_we     = we_r;
  assign dev.dev_addr   = addr_r;
  assign dev.dev_wdata  = wdata_r;
  assign cpu_read_result = rdata_r;
  assign hwirq           = hwirq_r;

endmodule

// File: tb/tb_bridge_fsm.sv
// Directed self-checking bench for bridge_fsm: load, store, timeout, illegal
// decode, stop, mid-transaction reset and interrupt synchronisation.
module tb_bridge_fsm;
  import bridge_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        dev_write_enable;
  logic [2:0]  dm_mode;
  logic [31:0] cpu_write_data;
  logic        bridge_stop;
  logic [31:0] cpu_read_result;
  logic        bridge_valid;
  logic        bridge_busy;
  logic [7:2]  hwirq;

  int errors = 0;
  int checks = 0;

  bridge_fsm_if dbus ();

  bridge_fsm #(.TIMEOUT(15)) dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_req          (cpu_req),
    .cpu_addr         (cpu_addr),
    .dev_write_enable (dev_write_enable),
    .dm_mode          (dm_mode),
    .cpu_write_data   (cpu_write_data),
    .bridge_stop      (bridge_stop),
    .cpu_read_result  (cpu_read_result),
    .bridge_valid     (bridge_valid),
    .bridge_busy      (bridge_busy),
    .hwirq            (hwirq),
    .dev              (dbus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic we,
                       input logic [2:0] mode, input logic [31:0] wd, input logic stop);
    cpu_req          = req;
    cpu_addr         = addr;
    dev_write_enable = we;
    dm_mode          = mode;
    cpu_write_data   = wd;
    bridge_stop      = stop;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0, DM_WORD, 32'd0, 1'b0);
    dbus.dev_ack    = 3'b000;
    dbus.dev_rdata0 = 32'd0;
    dbus.dev_rdata1 = 32'd0;
    dbus.dev_rdata2 = 32'd0;
    dbus.dev_irq    = 6'd0;
    step(); step(); sample();
    checks++; if (dbus.dev_req !== 3'b000) begin errors++; $display("FAIL reset_dev_req: got %b want 000", dbus.dev_req); end
    checks++; if (dbus.dev_we !== 1'b0) begin errors++; $display("FAIL reset_dev_we: got %b want 0", dbus.dev_we); end
    checks++; if (dbus.dev_addr !== 2'd0) begin errors++; $display("FAIL reset_dev_addr: got %0d want 0", dbus.dev_addr); end
    checks++; if (dbus.dev_wdata !== 32'd0) begin errors++; $display("FAIL reset_dev_wdata: got %h want 0", dbus.dev_wdata); end
    checks++; if (cpu_read_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", cpu_read_result); end
    checks++; if (hwirq !== 6'd0) begin errors++; $display("FAIL reset_hwirq: got %b want 0", hwirq); end
    checks++; if (bridge_busy !== 1'b0 || bridge_valid !== 1'b1) begin errors++; $display("FAIL reset_busy_valid: got busy=%b valid=%b want 0/1", bridge_busy, bridge_valid); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_load();
    step();
    drive(1'b1, 32'h0000_7F14, 1'b0, DM_WORD, 32'd0, 1'b0);
    dbus.dev_rdata1 = 32'hDEAD_BEEF;
    sample();
    checks++; if (bridge_busy !== 1'b1 || bridge_valid !== 1'b1) begin errors++; $display("FAIL load_launch: got busy=%b valid=%b want 1/1", bridge_busy, bridge_valid); end
    checks++; if (dbus.dev_req !== 3'b000) begin errors++; $display("FAIL load_idle_req: got %b want 000", dbus.dev_req); end
    step();
    dbus.dev_ack = 3'b010;
    sample();
    checks++; if (dbus.dev_req !== 3'b010) begin errors++; $display("FAIL load_dev_req: got %b want 010", dbus.dev_req); end
    checks++; if (dbus.dev_addr !== 2'd1 || dbus.dev_we !== 1'b0) begin errors++; $display("FAIL load_addr_we: got addr=%0d we=%b want 1/0", dbus.dev_addr, dbus.dev_we); end
    checks++; if (bridge_busy !== 1'b1) begin errors++; $display("FAIL load_req_busy: got %b want 1", bridge_busy); end
    step();
    dbus.dev_ack = 3'b000;
    sample();
    checks++; if (bridge_busy !== 1'b0 || dbus.dev_req !== 3'b000) begin errors++; $display("FAIL load_done: got busy=%b req=%b want 0/000", bridge_busy, dbus.dev_req); end
    checks++; if (cpu_read_result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data: got %h want deadbeef", cpu_read_result); end
    step();
    drive(1'b0, 32'd0, 1'b0, DM_WORD, 32'd0, 1'b0);
    sample();
    checks++; if (bridge_busy !== 1'b0 || dbus.dev_req !== 3'b000) begin errors++; $display("FAIL load_no_relaunch: got busy=%b req=%b want 0/000", bridge_busy, dbus.dev_req); end
    checks++; if (cpu_read_result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_hold: got %h want deadbeef", cpu_read_result); end
  endtask

  task automatic test_store();
    int n;
    step();
    drive(1'b1, 32'h0000_7F08, 1'b1, DM_WORD, 32'h1234_5678, 1'b0);
    dbus.dev_rdata0 = 32'hFFFF_0000;
    sample();
    n = bridge_busy ? 1 : 0;
    for (int r = 1; r <= 4; r++) begin
      step();
      if (r == 4) dbus.dev_ack = 3'b001;
      sample();
      if (bridge_busy) n++;
      checks++; if (dbus.dev_we !== 1'b1 || dbus.dev_wdata !== 32'h1234_5678) begin errors++; $display("FAIL store_we_wdata[%0d]: got we=%b wdata=%h want 1/12345678", r, dbus.dev_we, dbus.dev_wdata); end
      checks++; if (dbus.dev_req !== 3'b001 || dbus.dev_addr !== 2'd2) begin errors++; $display("FAIL store_req_addr[%0d]: got req=%b addr=%0d want 001/2", r, dbus.dev_req, dbus.dev_addr); end
    end
    step();
    dbus.dev_ack = 3'b000;
    sample();
    if (bridge_busy) n++;
    checks++; if (n !== 5) begin errors++; $display("FAIL store_busy_cycles: got %0d want 5", n); end
    checks++; if (cpu_read_result !== 32'd0) begin errors++; $display("FAIL store_result: got %h want 0", cpu_read_result); end
    step();
    drive(1'b0, 32'd0, 1'b0, DM_WORD, 32'd0, 1'b0);
  endtask

  task automatic test_timeout();
    int n;
    // Give the result a nonzero value first so the timeout clear is visible.
    step();
    drive(1'b1, 32'h0000_7F20, 1'b0, DM_WORD, 32'd0, 1'b0);
    dbus.dev_rdata2 = 32'h5555_AAAA;
    dbus.dev_ack    = 3'b100;
    step(); step();
    dbus.dev_ack = 3'b000;
    drive(1'b0, 32'd0, 1'b0, DM_WORD, 32'd0, 1'b0);
    sample();
    checks++; if (cpu_read_result !== 32'h5555_AAAA) begin errors++; $display("FAIL timeout_pre_data: got %h want 5555aaaa", cpu_read_result); end
    step();
    drive(1'b1, 32'h0000_7F2C, 1'b0, DM_WORD, 32'd0, 1'b0);
    sample();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bridge_busy) break;
      n++;
      if (n == 3) begin
        checks++; if (dbus.dev_req !== 3'b100 || dbus.dev_addr !== 2'd3) begin errors++; $display("FAIL timeout_req: got req=%b addr=%0d want 100/3", dbus.dev_req, dbus.dev_addr); end
      end
      dbus.dev_ack = (n == 5) ? 3'b001 : 3'b000;
      @(negedge clk);
    end
    dbus.dev_ack = 3'b000;
    checks++; if (n !== 17) begin errors++; $display("FAIL timeout_busy_cycles: got %0d want 17", n); end
    checks++; if (cpu_read_result !== 32'd0) begin errors++; $display("FAIL timeout_result: got %h want 0", cpu_read_result); end
    checks++; if (dbus.dev_req !== 3'b000) begin errors++; $display("FAIL timeout_done_req: got %b want 000", dbus.dev_req); end
    step();
    drive(1'b0, 32'd0, 1'b0, DM_WORD, 32'd0, 1'b0);
    sample();
    checks++; if (bridge_busy !== 1'b0 || dbus.dev_req !== 3'b000) begin errors++; $display("FAIL timeout_idle: got busy=%b req=%b want 0/000", bridge_busy, dbus.dev_req); end
  endtask

  task automatic test_illegal();
    logic [31:0] addrs [3];
    logic [2:0]  modes [3];
    addrs[0] = 32'h0000_7F30; modes[0] = DM_WORD;
    addrs[1] = 32'h0000_7F00; modes[1] = DM_BYTE;
    addrs[2] = 32'h0000_7F02; modes[2] = DM_WORD;
    for (int k = 0; k < 3; k++) begin
      step();
      drive(1'b1, addrs[k], 1'b0, modes[k], 32'd0, 1'b0);
      sample();
      checks++; if (bridge_valid !== 1'b0 || bridge_busy !== 1'b0) begin errors++; $display("FAIL illegal_valid_busy[%0d]: got valid=%b busy=%b want 0/0", k, bridge_valid, bridge_busy); end
      step();
      sample();
      checks++; if (dbus.dev_req !== 3'b000) begin errors++; $display("FAIL illegal_no_req[%0d]: got %b want 000", k, dbus.dev_req); end
    end
    step();
    drive(1'b0, 32'h0000_7F30, 1'b0, DM_BYTE, 32'd0, 1'b0);
    sample();
    checks++; if (bridge_valid !== 1'b1) begin errors++; $display("FAIL idle_valid: got %b want 1", bridge_valid); end
  endtask

  task automatic test_stop();
    step();
    drive(1'b1, 32'h0000_7F10, 1'b0, DM_WORD, 32'd0, 1'b1);
    dbus.dev_rdata1 = 32'h0BAD_F00D;
    sample();
    checks++; if (bridge_busy !== 1'b0 || bridge_valid !== 1'b1) begin errors++; $display("FAIL stop_idle: got busy=%b valid=%b want 0/1", bridge_busy, bridge_valid); end
    step();
    sample();
    checks++; if (dbus.dev_req !== 3'b000) begin errors++; $display("FAIL stop_no_launch: got %b want 000", dbus.dev_req); end
    step();
    bridge_stop = 1'b0;
    sample();
    checks++; if (bridge_busy !== 1'b1) begin errors++; $display("FAIL stop_release_launch: got %b want 1", bridge_busy); end
    step();
    bridge_stop = 1'b1;
    sample();
    checks++; if (dbus.dev_req !== 3'b010 || bridge_busy !== 1'b1) begin errors++; $display("FAIL stop_in_req: got req=%b busy=%b want 010/1", dbus.dev_req, bridge_busy); end
    step();
    dbus.dev_ack = 3'b010;
    sample();
    checks++; if (bridge_busy !== 1'b1) begin errors++; $display("FAIL stop_req_held: got %b want 1", bridge_busy); end
    step();
    dbus.dev_ack = 3'b000;
    sample();
    checks++; if (bridge_busy !== 1'b0 || cpu_read_result !== 32'h0BAD_F00D) begin errors++; $display("FAIL stop_complete: got busy=%b data=%h want 0/0badf00d", bridge_busy, cpu_read_result); end
    step();
    drive(1'b0, 32'd0, 1'b0, DM_WORD, 32'd0, 1'b0);
  endtask

  task automatic test_rst_mid();
    step();
    drive(1'b1, 32'h0000_7F24, 1'b0, DM_WORD, 32'd0, 1'b0);
    step();
    sample();
    checks++; if (dbus.dev_req !== 3'b100) begin errors++; $display("FAIL rstmid_req: got %b want 100", dbus.dev_req); end
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0, DM_WORD, 32'd0, 1'b0);
    step();
    dbus.dev_ack = 3'b100;
    rst = 1'b0;
    sample();
    checks++; if (dbus.dev_req !== 3'b000 || cpu_read_result !== 32'd0) begin errors++; $display("FAIL rstmid_clear: got req=%b data=%h want 000/0", dbus.dev_req, cpu_read_result); end
    step();
    sample();
    checks++; if (bridge_busy !== 1'b0 || cpu_read_result !== 32'd0) begin errors++; $display("FAIL rstmid_no_ack: got busy=%b data=%h want 0/0", bridge_busy, cpu_read_result); end
    dbus.dev_ack = 3'b000;
  endtask

  task automatic test_irq();
    step();
    dbus.dev_irq = 6'b000001;
    step(); step();
    sample();
    checks++; if (hwirq !== 6'b000001) begin errors++; $display("FAIL irq_first: got %b want 000001", hwirq); end
    dbus.dev_irq = 6'b100001;
    step();
    sample();
    checks++; if (hwirq !== 6'b000001) begin errors++; $display("FAIL irq_latency: got %b want 000001", hwirq); end
    step();
    sample();
    checks++; if (hwirq !== 6'b100001) begin errors++; $display("FAIL irq_second: got %b want 100001", hwirq); end
    rst = 1'b1;
    step();
    sample();
    checks++; if (hwirq !== 6'd0) begin errors++; $display("FAIL irq_reset: got %b want 000000", hwirq); end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_illegal();
    test_stop();
    test_rst_mid();
    test_irq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bridge_fsm.md
Name: bridge_fsm

Overview:
- Memory-mapped I/O bridge directly downstream of the pipelined CPU's M stage.
- Consumes the CPU's device-access outputs: address, write enable, DM mode, write data and stop.
- Decodes the access to one of three device slots and runs a req/ack transaction with wait states and a timeout.
- Returns read data, the legality flag (bridge_valid) and a pipeline-stall flag, and synchronises device interrupt lines into hwirq[7:2].

Parameters:
- BASE0, 32'h0000_7F00, base of device slot 0 (16-byte window)
- BASE1, 32'h0000_7F10, base of device slot 1
- BASE2, 32'h0000_7F20, base of device slot 2
- TIMEOUT, 15, maximum REQ cycles before the bridge force-completes; must be at least 1, counter width is $clog2(TIMEOUT+1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  M stage holds a load/store targeting the bridge
- cpu_addr  in  32  byte address
- dev_write_enable  in  1  store when 1, load when 0
- dm_mode  in  3  access width, shared DM_* encoding
- cpu_write_data  in  32  store data
- bridge_stop  in  1  suppress launch (exception/flush in M)
- cpu_read_result  out  32  load data
- bridge_valid  out  1  access legal
- bridge_busy  out  1  stall pipeline
- hwirq  out  6  [7:2], synchronised interrupts
- dev_req  out  3  one-hot request per slot
- dev_we  out  1  write strobe qualifier
- dev_addr  out  2  word offset inside slot (addr[3:2])
- dev_wdata  out  32  write data
- dev_ack  in  3  per-slot acknowledge
- dev_rdata0 / dev_rdata1 / dev_rdata2  in  32 each  per-slot read data
- dev_irq  in  6  raw device interrupts

Behaviour:
- Decode is combinational. hit_i = (cpu_addr[31:4] == BASEi[31:4]).
- legal = one hit_i & dm_mode == DM_WORD & cpu_addr[1:0] == 0.
- bridge_valid = !cpu_req | legal, combinational in every state so the CPU can raise its address exception in the same cycle.
- States are IDLE, REQ and DONE. Reset: state IDLE, dev_req 0, dev_we 0, dev_addr 0, dev_wdata 0, cpu_read_result 0, timeout counter 0, hwirq 0.
- IDLE, launch = cpu_req & legal & !bridge_stop:
  - bridge_busy = launch, combinational.
  - On launch, latch sel, we, addr[3:2] and wdata, clear the counter, go to REQ.
  - Otherwise stay in IDLE with dev_req 0.
- REQ:
  - dev_req[sel] = 1 with dev_we, dev_addr and dev_wdata held stable; bridge_busy = 1.
  - dev_ack[sel] = 1: capture dev_rdata[sel] (loads only, stores capture 0) into cpu_read_result and go to DONE.
  - Counter == TIMEOUT with no ack: cpu_read_result = 0 and go to DONE.
  - Otherwise the counter increments.
  - Acks on unselected slots are ignored.
  - bridge_stop is ignored in REQ: a launched transaction always completes.
- DONE: bridge_busy = 0, dev_req = 0, cpu_read_result holds; the pipeline advances at this edge. Always go to IDLE and never relaunch from DONE, even though cpu_req is still high for the same instruction.
- Latency:
  - Ack in the first REQ cycle: busy for 2 cycles, data valid in the 3rd cycle (DONE).
  - No ack: busy for TIMEOUT+2 cycles.
- cpu_read_result changes only on capture, on timeout, or under rst.
- hwirq is a 2-flop synchroniser of dev_irq; 2-cycle latency.
- Reset mid-transaction returns to IDLE within one edge, with dev_req cleared and no further ack sampling.

Decomposition:
- Shared header holds:
  - DM_WORD / DM_HALF / DM_BYTE encodings
  - state encodings BR_IDLE / BR_REQ / BR_DONE
  - default base addresses
- Sub-module addr_decode (combinational): cpu_addr + dm_mode -> one-hot hit[2:0] and legal.
- FSM, counter, data capture and irq synchroniser live in bridge_fsm.

Test Plan:
- Legal load: cpu_req=1, addr 32'h7F14, DM_WORD, slot 1 acks in the first REQ cycle with 32'hDEADBEEF. Expected: dev_req=3'b010, dev_addr=2'd1, busy high for 2 cycles, cpu_read_result=32'hDEADBEEF in DONE, then IDLE.
- Store: addr 32'h7F08, data 32'h12345678, ack after 3 cycles. Expected: dev_we=1, dev_wdata=32'h12345678 stable for 4 REQ cycles, dev_req=3'b001, busy for 5 cycles.
- Illegal access: addr 32'h7F30, or DM_BYTE to 32'h7F00, or addr 32'h7F02. Expected: bridge_valid=0, no dev_req, busy=0. With cpu_req=0: bridge_valid=1.
- Timeout: TIMEOUT=15, slot 2 read never acks. Expected: busy for 17 cycles, cpu_read_result=0, return to IDLE; a stray dev_ack[0] during REQ is ignored.
- Stop/reset: bridge_stop=1 with a legal request in IDLE gives no launch. bridge_stop=1 during REQ still completes the transaction. rst during REQ gives IDLE, dev_req=0, cpu_read_result=0 on the next edge.
- Interrupts: dev_irq goes 6'b000001 -> 6'b100001. Expected: hwirq follows two cycles later; rst clears it to 0.
